cc_branch_unit: RTL

//  Sequential condition/branch resolver for the m68000 core. Holds the architectural CCR copy, evaluates the
//  16 Motorola condition tests and resolves Bcc, Scc, DBcc and TRAPcc, including the DBcc counter decrement.

---
 rtl/cc_branch_unit_pkg.sv | 28 ++
 rtl/cc_branch_unit_if.sv | 23 ++
 rtl/cc_branch_unit_cc_test.sv | 37 +++
 rtl/cc_branch_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/cc_branch_unit_pkg.sv
// m68k_cond_pkg: condition codes, request modes, FSM states and CCR bit positions for cc_branch_unit
package m68k_cond_pkg;
  localparam logic [3:0] CC_T  = 4'h0;
  localparam logic [3:0] CC_F  = 4'h1;
  localparam logic [3:0] CC_HI = 4'h2;
  localparam logic [3:0] CC_LS = 4'h3;
  localparam logic [3:0] CC_CC = 4'h4;
  localparam logic [3:0] CC_CS = 4'h5;
  localparam logic [3:0] CC_NE = 4'h6;
  localparam logic [3:0] CC_EQ = 4'h7;
  localparam logic [3:0] CC_VC = 4'h8;
  localparam logic [3:0] CC_VS = 4'h9;
  localparam logic [3:0] CC_PL = 4'hA;
  localparam logic [3:0] CC_MI = 4'hB;
  localparam logic [3:0] CC_GE = 4'hC;
  localparam logic [3:0] CC_LT = 4'hD;
  localparam logic [3:0] CC_GT = 4'hE;
  localparam logic [3:0] CC_LE = 4'hF;
  localparam logic [1:0] MODE_BCC    = 2'b00;
  localparam logic [1:0] MODE_SCC    = 2'b01;
  localparam logic [1:0] MODE_DBCC   = 2'b10;
  localparam logic [1:0] MODE_TRAPCC = 2'b11;
  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_DEC, ST_RESP} state_t;
endpackage

// File: rtl/cc_branch_unit_if.sv
// cc_branch_unit_if: request and response handshakes between sequencer and branch unit
interface cc_branch_unit_if #(parameter int CNT_W = 16);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [3:0]       req_cond;
  logic [CNT_W-1:0] req_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_taken;
  logic             rsp_trap;
  logic [7:0]       rsp_scc;
  logic [CNT_W-1:0] rsp_count;
  logic             rsp_cnt_we;
  modport master (
    output req_valid, req_mode, req_cond, req_count, rsp_ready,
    input  req_ready, rsp_valid, rsp_taken, rsp_trap, rsp_scc, rsp_count, rsp_cnt_we
  );
  modport slave (
    input  req_valid, req_mode, req_cond, req_count, rsp_ready,
    output req_ready, rsp_valid, rsp_taken, rsp_trap, rsp_scc, rsp_count, rsp_cnt_we
  );
endinterface

// File: rtl/cc_branch_unit_cc_test.sv
// cc_test: evaluates one of the 16 Motorola condition tests against N,Z,V,C
module cc_test
  import m68k_cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzvc_i,
  output logic       pass_o
);
  logic n, z, v, c;
  assign n = nzvc_i[CCR_N];
  assign z = nzvc_i[CCR_Z];
  assign v = nzvc_i[CCR_V];
  assign c = nzvc_i[CCR_C];
  // decode the condition into its flag expression
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      CC_T:  pass_o = 1'b1;
      CC_F:  pass_o = 1'b0;
      CC_HI: pass_o = ~c & ~z;
      CC_LS: pass_o = c | z;
      CC_CC: pass_o = ~c;
      CC_CS: pass_o = c;
      CC_NE: pass_o = ~z;
      CC_EQ: pass_o = z;
      CC_VC: pass_o = ~v;
      CC_VS: pass_o = v;
      CC_PL: pass_o = ~n;
      CC_MI: pass_o = n;
      CC_GE: pass_o = n ~^ v;
      CC_LT: pass_o = n ^ v;
      CC_GT: pass_o = ~z & (n ~^ v);
      CC_LE: pass_o = z | (n ^ v);
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/cc_branch_unit.sv
// cc_branch_unit: CCR copy plus Bcc/Scc/DBcc/TRAPcc resolver with DBcc counter decrement
module cc_branch_unit
  import m68k_cond_pkg::*;
#(
  parameter int               CNT_W   = 16,
  parameter int               CCR_W   = 8,
  parameter logic [CCR_W-1:0] CCR_RST = '0,
  parameter bit               FORWARD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ccr_we_i,
  input  logic [CCR_W-1:0] ccr_wdata_i,
  output logic [CCR_W-1:0] ccr_q_o,
  cc_branch_unit_if.slave  bus
);
  state_t           state_q;
  logic [CCR_W-1:0] ccr_q, ccr_d;
  logic [1:0]       mode_q;
  logic [3:0]       cond_q;
  logic [CNT_W-1:0] count_q, count_d, rsp_count_q;
  logic             req_ready_q, rsp_valid_q, taken_q, trap_q, cnt_we_q;
  logic [7:0]       scc_q;
  logic [3:0]       nzvc;
  logic             pass, dec_taken;
  assign ccr_d     = ccr_we_i ? ccr_wdata_i : ccr_q;
  assign nzvc      = (FORWARD && ccr_we_i) ? ccr_wdata_i[3:0] : ccr_q[3:0];
  assign count_d   = count_q - CNT_W'(1);
  assign dec_taken = count_d != '1;
  cc_test u_test (.cond_i(cond_q), .nzvc_i(nzvc), .pass_o(pass));
  // architectural CCR copy, written whenever strobed regardless of FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ccr_q <= CCR_RST;
    else        ccr_q <= ccr_d;
  end
  // request FSM with registered handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_BCC;
      cond_q      <= CC_T;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      trap_q      <= 1'b0;
      scc_q       <= 8'h00;
      rsp_count_q <= '0;
      cnt_we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.req_valid) begin
          mode_q      <= bus.req_mode;
          cond_q      <= bus.req_cond;
          count_q     <= bus.req_count;
          req_ready_q <= 1'b0;
          state_q     <= ST_EVAL;
        end
        ST_EVAL: if (mode_q == MODE_DBCC && !pass) begin
          state_q <= ST_DEC;
        end else begin
          rsp_valid_q <= 1'b1;
          taken_q     <= pass && (mode_q == MODE_BCC || mode_q == MODE_SCC);
          trap_q      <= pass && mode_q == MODE_TRAPCC;
          scc_q       <= (pass && mode_q == MODE_SCC) ? 8'hFF : 8'h00;
          rsp_count_q <= count_q;
          cnt_we_q    <= 1'b0;
          state_q     <= ST_RESP;
        end
        ST_DEC: begin
          rsp_valid_q <= 1'b1;
          taken_q     <= dec_taken;
          trap_q      <= 1'b0;
          scc_q       <= 8'h00;
          rsp_count_q <= count_d;
          cnt_we_q    <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          taken_q     <= 1'b0;
          trap_q      <= 1'b0;
          scc_q       <= 8'h00;
          rsp_count_q <= '0;
          cnt_we_q    <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign ccr_q_o        = ccr_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_taken  = taken_q;
  assign bus.rsp_trap   = trap_q;
  assign bus.rsp_scc    = scc_q;
  assign bus.rsp_count  = rsp_count_q;
  assign bus.rsp_cnt_we = cnt_we_q;
endmodule
